scoreboard_multi: RTL

SCOREBOARD_MULTI -- requirements
Module: scoreboard_multi

---
 rtl/scoreboard_pkg.sv | 12 +
 rtl/sb_clear_match.sv | 44 ++++
 rtl/scoreboard_multi.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/scoreboard_pkg.sv
// Shared tag encoding for the register scoreboard.
// A tag is 0 when the register is free, or k+1 when functional unit k owns it.
// tag_width() returns the number of bits needed for tags 0..NUM_FU.
package scoreboard_pkg;

    localparam int TAG_FREE = 0;

    function automatic int tag_width(input int num_fu);
        return $clog2(num_fu + 1);
    endfunction

endpackage

// File: rtl/sb_clear_match.sv
// Purpose: per-register clear vector and clear count from the FU completion strobes.
// Latency: purely combinational (0 cycles).
// Backpressure: none. A completion whose FU does not own the register is dropped as stale.
// Ports: i_done_valid/i_done_rd  per-FU completions, FU k's register at [k*REG_W +: REG_W]
//        i_status_flat           current tags, register r at [r*TAG_W +: TAG_W]
//        o_clr_vec/o_clr_cnt     registers to free at the next edge, and how many there are
module sb_clear_match
    import scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_FU   = 4,
    parameter int REG_W    = $clog2(NUM_REGS),
    parameter int TAG_W    = tag_width(NUM_FU),
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic [NUM_FU-1:0]         i_done_valid,
    input  logic [NUM_FU*REG_W-1:0]   i_done_rd,
    input  logic [NUM_REGS*TAG_W-1:0] i_status_flat,
    output logic [NUM_REGS-1:0]       o_clr_vec,
    output logic [CNT_W-1:0]          o_clr_cnt
);

    logic [CNT_W-1:0] w_cnt;

    // A register holds a single tag, so at most one FU can match it.
    // Counting set bits of the clear vector therefore counts distinct registers,
    // even when several FUs report the same register in one cycle.
    always_comb begin
        o_clr_vec = '0;
        w_cnt     = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (i_done_valid[k] &&
                    (i_done_rd[k*REG_W +: REG_W] == REG_W'(r)) &&
                    (i_status_flat[r*TAG_W +: TAG_W] == TAG_W'(k + 1))) begin
                    o_clr_vec[r] = 1'b1;
                end
            end
            w_cnt = w_cnt + CNT_W'(o_clr_vec[r]);
        end
        o_clr_cnt = w_cnt;
    end

endmodule

// File: rtl/scoreboard_multi.sv
// Purpose: register scoreboard tracking which FU owns each destination register.
//          It stalls issue on an illegal FU, a busy FU or a WAW hazard.
// Latency: issue to visible status 1 cycle; a completion bypasses the dependency outputs in the same cycle.
// Backpressure: stop_fetch is combinational from this cycle's issue inputs, fu_busy and registered status.
// Ports: issue_* / rs1 / rs2 / rd / rd_write  decoded instruction;  fu_busy, done_valid, done_rd  FU side;
//        stop_fetch, fu_load, data1/2_depend, outstanding, err_fu  outputs.
module scoreboard_multi
    import scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int NUM_FU   = 4,
    localparam int REG_W   = $clog2(NUM_REGS),
    localparam int TAG_W   = tag_width(NUM_FU),
    localparam int CNT_W   = $clog2(NUM_REGS + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue_valid,
    input  logic [TAG_W-1:0]          issue_fu,
    input  logic [REG_W-1:0]          rs1,
    input  logic [REG_W-1:0]          rs2,
    input  logic [REG_W-1:0]          rd,
    input  logic                      rd_write,
    input  logic [NUM_FU-1:0]         fu_busy,
    input  logic [NUM_FU-1:0]         done_valid,
    input  logic [NUM_FU*REG_W-1:0]   done_rd,
    output logic                      stop_fetch,
    output logic [NUM_FU-1:0]         fu_load,
    output logic [TAG_W-1:0]          data1_depend,
    output logic [TAG_W-1:0]          data2_depend,
    output logic [CNT_W-1:0]          outstanding,
    output logic                      err_fu
);

    logic [TAG_W-1:0]          r_status [NUM_REGS];
    logic [CNT_W-1:0]          r_outstanding;
    logic                      r_err_fu;

    logic [NUM_REGS*TAG_W-1:0] w_status_flat;
    logic [NUM_REGS-1:0]       w_clr_vec;
    logic [CNT_W-1:0]          w_clr_cnt;
    logic [NUM_REGS-1:0]       w_set_vec;
    logic                      w_illegal;
    logic                      w_busy;
    logic                      w_waw;
    logic                      w_fire;
    logic                      w_mark;
    logic                      w_set_hides_clr;
    logic [TAG_W-1:0]          w_tag1;
    logic [TAG_W-1:0]          w_tag2;

    always_comb begin
        w_status_flat = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_status_flat[r*TAG_W +: TAG_W] = r_status[r];
        end
    end

    sb_clear_match #(
        .NUM_REGS (NUM_REGS),
        .NUM_FU   (NUM_FU),
        .REG_W    (REG_W),
        .TAG_W    (TAG_W),
        .CNT_W    (CNT_W)
    ) u_clear_match (
        .i_done_valid  (done_valid),
        .i_done_rd     (done_rd),
        .i_status_flat (w_status_flat),
        .o_clr_vec     (w_clr_vec),
        .o_clr_cnt     (w_clr_cnt)
    );

    assign w_illegal = issue_fu >= TAG_W'(NUM_FU);

    // Select by comparison, not by indexing: an illegal issue_fu would index past fu_busy.
    always_comb begin
        w_busy = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (issue_fu == TAG_W'(k)) begin
                w_busy = fu_busy[k];
            end
        end
    end

    // WAW uses registered status only. A same-cycle completion of rd still stalls for one cycle.
    assign w_waw      = rd_write && (rd != '0) && (r_status[rd] != TAG_W'(TAG_FREE));
    assign stop_fetch = issue_valid && (w_illegal || w_busy || w_waw);
    assign w_fire     = issue_valid && !stop_fetch;
    assign w_mark     = w_fire && rd_write && (rd != '0);

    always_comb begin
        fu_load = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            fu_load[k] = w_fire && (issue_fu == TAG_W'(k));
        end
    end

    always_comb begin
        w_set_vec = '0;
        if (w_mark) begin
            w_set_vec[rd] = 1'b1;
        end
    end

    // Set wins over clear on the same register.
    // That clear must then not be counted as leaving the outstanding set.
    assign w_set_hides_clr = w_mark && w_clr_vec[rd];

    // Same-cycle bypass: a source whose owning FU completes it right now reads as ready.
    assign w_tag1 = r_status[rs1];
    assign w_tag2 = r_status[rs2];

    always_comb begin
        data1_depend = w_tag1;
        data2_depend = w_tag2;
        for (int k = 0; k < NUM_FU; k++) begin
            if (done_valid[k] && (w_tag1 == TAG_W'(k + 1)) &&
                (done_rd[k*REG_W +: REG_W] == rs1)) begin
                data1_depend = TAG_W'(TAG_FREE);
            end
            if (done_valid[k] && (w_tag2 == TAG_W'(k + 1)) &&
                (done_rd[k*REG_W +: REG_W] == rs2)) begin
                data2_depend = TAG_W'(TAG_FREE);
            end
        end
        if (rs1 == '0) begin
            data1_depend = TAG_W'(TAG_FREE);
        end
        if (rs2 == '0) begin
            data2_depend = TAG_W'(TAG_FREE);
        end
    end

    // Register 0 is never written after reset, so it reads as free forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_status[r] <= TAG_W'(TAG_FREE);
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (w_set_vec[r]) begin
                    r_status[r] <= issue_fu + TAG_W'(1);
                end else if (w_clr_vec[r]) begin
                    r_status[r] <= TAG_W'(TAG_FREE);
                end
            end
        end
    end

    // A mark only happens on a free register and a clear only on an owned one.
    // So this count tracks the number of owned registers and stays within 0..NUM_REGS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_err_fu      <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_mark)
                             - (w_clr_cnt - CNT_W'(w_set_hides_clr));
            r_err_fu      <= r_err_fu || (issue_valid && w_illegal);
        end
    end

    assign outstanding = r_outstanding;
    assign err_fu      = r_err_fu;

endmodule
